// File: rtl/pwm_generator_if.sv
// Connection between the PWM CSR block (master) and the PWM counter core (slave).
// Carries the run request and configuration down, and the waveform and status back up.
interface pwm_generator_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty_cycle;
    logic [WIDTH-1:0] divisor;
    logic             pwm_out;
    logic             pwm_running;
    logic             period_done;

    modport master (
        output enable, period, duty_cycle, divisor,
        input  pwm_out, pwm_running, period_done
    );

    modport slave (
        input  enable, period, duty_cycle, divisor,
        output pwm_out, pwm_running, period_done
    );
endinterface

// File: rtl/pwm_generator.sv
// PWM counter/comparator core with a prescaler and double-buffered configuration.
// Shadows reload only at start-up and at period boundaries, so CSR writes never glitch the output.
module pwm_generator #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    pwm_generator_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_pre_cnt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period_sh;
    logic [WIDTH-1:0] r_duty_sh;
    logic [WIDTH-1:0] r_divisor_sh;
    logic             r_pwm_out;
    logic             r_running;
    logic             r_period_done;

    logic [WIDTH-1:0] w_pre_nx;
    logic [WIDTH-1:0] w_cnt_nx;
    logic [WIDTH-1:0] w_period_nx;
    logic [WIDTH-1:0] w_duty_nx;
    logic [WIDTH-1:0] w_divisor_nx;
    logic [WIDTH-1:0] w_div_eff;
    logic [WIDTH-1:0] w_div_eff_nx;
    logic             w_tick;
    logic             w_last;
    logic             w_load;
    logic             w_advance;
    logic             w_run_nx;
    logic             w_out_nx;
    logic             w_done_nx;

    assign w_div_eff = (r_divisor_sh == '0) ? ONE : r_divisor_sh;
    assign w_tick    = (r_pre_cnt == w_div_eff - ONE);
    assign w_last    = (r_state != S_IDLE) && (r_period_sh != '0) && w_tick
                    && (r_cnt == r_period_sh - ONE);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_state_nx = r_state;
        w_pre_nx   = r_pre_cnt;
        w_cnt_nx   = r_cnt;
        w_load     = 1'b0;
        w_advance  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_pre_nx = '0;
                w_cnt_nx = '0;
                if (bus.enable) begin
                    w_state_nx = S_RUN;
                    w_load     = 1'b1;
                end
            end
            S_RUN: begin
                if (r_period_sh == '0) begin
                    // Degenerate period: keep sampling inputs so a real period starts at once.
                    w_load   = 1'b1;
                    w_pre_nx = '0;
                    w_cnt_nx = '0;
                    if (!bus.enable) w_state_nx = S_IDLE;
                end else begin
                    w_advance = 1'b1;
                    w_load    = w_last;
                    if (!bus.enable) w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_period_sh == '0) begin
                    w_state_nx = S_IDLE;
                    w_pre_nx   = '0;
                    w_cnt_nx   = '0;
                end else if (bus.enable) begin
                    w_state_nx = S_RUN;
                    w_advance  = 1'b1;
                    w_load     = w_last;
                end else if (w_last) begin
                    w_state_nx = S_IDLE;
                    w_pre_nx   = '0;
                    w_cnt_nx   = '0;
                end else begin
                    w_advance = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_pre_nx   = '0;
                w_cnt_nx   = '0;
            end
        endcase

        if (w_advance) begin
            if (w_tick) begin
                w_pre_nx = '0;
                w_cnt_nx = (r_cnt == r_period_sh - ONE) ? '0 : r_cnt + ONE;
            end else begin
                w_pre_nx = r_pre_cnt + ONE;
            end
        end
    end

    assign w_period_nx  = w_load ? bus.period     : r_period_sh;
    assign w_duty_nx    = w_load ? bus.duty_cycle : r_duty_sh;
    assign w_divisor_nx = w_load ? bus.divisor    : r_divisor_sh;
    assign w_div_eff_nx = (w_divisor_nx == '0) ? ONE : w_divisor_nx;

    // Outputs are decoded from next-state values and registered, so they line up with the counters.
    assign w_run_nx  = (w_state_nx != S_IDLE);
    assign w_out_nx  = w_run_nx && (w_period_nx != '0) && (w_cnt_nx < w_duty_nx);
    assign w_done_nx = w_run_nx && (w_period_nx != '0)
                    && (w_pre_nx == w_div_eff_nx - ONE) && (w_cnt_nx == w_period_nx - ONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pre_cnt     <= '0;
            r_cnt         <= '0;
            r_period_sh   <= '0;
            r_duty_sh     <= '0;
            r_divisor_sh  <= '0;
            r_pwm_out     <= 1'b0;
            r_running     <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_pre_cnt     <= w_pre_nx;
            r_cnt         <= w_cnt_nx;
            r_period_sh   <= w_period_nx;
            r_duty_sh     <= w_duty_nx;
            r_divisor_sh  <= w_divisor_nx;
            r_pwm_out     <= w_out_nx;
            r_running     <= w_run_nx;
            r_period_done <= w_done_nx;
        end
    end

    assign bus.pwm_out     = r_pwm_out;
    assign bus.pwm_running = r_running;
    assign bus.period_done = r_period_done;
endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: expected {pwm_out, period_done, pwm_running} per clk
// is queued when stimulus is applied and compared on each falling edge.
module tb_pwm_generator;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pwm_generator_if #(.WIDTH(WIDTH)) bus ();

    pwm_generator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] exp;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [2:0] sample();
        return {bus.pwm_out, bus.period_done, bus.pwm_running};
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed {out,done,run}=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic o, input logic d, input logic r, input string tag);
        exp_t e;
        e.exp = {o, d, r};
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // One complete period straight from the waveform definition: high for the first
    // min(duty,period)*div_eff clks, period_done on the last of period*div_eff clks.
    task automatic push_period(input int p, input int d, input int div, input string tag);
        int de;
        de = (div == 0) ? 1 : div;
        for (int c = 0; c < p * de; c++)
            push((c / de) < d, c == p * de - 1, 1'b1, tag);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && sb_q.size() != 0; i++) begin
            exp_t e;
            @(negedge clk);
            e = sb_q.pop_front();
            check(e.tag, sample(), e.exp);
        end
    endtask

    task automatic drain_all();
        drain(sb_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.period     = 16'd4;
        bus.duty_cycle = 16'd1;
        bus.divisor    = 16'd2;

        // Reset holds everything low even with live inputs.
        push(1'b0, 1'b0, 1'b0, "reset_hold");
        push(1'b0, 1'b0, 1'b0, "reset_hold");
        drain_all();
        reset      = 1'b0;
        bus.enable = 1'b0;
        push(1'b0, 1'b0, 1'b0, "idle_after_reset");
        drain_all();

        // period=4 duty=1 divisor=2: 2 high, 6 low, done every 8 clk.
        bus.enable = 1'b1;
        push_period(4, 1, 2, "p4_d1_div2");
        push_period(4, 1, 2, "p4_d1_div2");
        drain_all();

        // Written in the last cycle, so each applies to the very next period.
        bus.divisor = 16'd0;
        push_period(4, 1, 0, "div0");
        drain_all();
        bus.divisor = 16'd1;
        push_period(4, 1, 1, "div1");
        drain_all();

        // Mid-period duty change waits for the boundary.
        push_period(4, 1, 1, "duty_old");
        push_period(4, 3, 1, "duty_new");
        drain(2);
        bus.duty_cycle = 16'd3;
        drain_all();

        bus.duty_cycle = 16'd5;
        push_period(4, 5, 1, "duty_over");
        push_period(4, 5, 1, "duty_over");
        drain_all();
        bus.duty_cycle = 16'd0;
        push_period(4, 0, 1, "duty_zero");
        push_period(4, 0, 1, "duty_zero");
        drain_all();

        // Drain: enable drops at cnt=2, the period completes, then running falls.
        bus.period     = 16'd8;
        bus.duty_cycle = 16'd3;
        push_period(8, 3, 1, "drain_a");
        push(1'b0, 1'b0, 1'b0, "drain_a_idle");
        push(1'b0, 1'b0, 1'b0, "drain_a_idle");
        drain(3);
        bus.enable = 1'b0;
        drain_all();

        // Drain cancelled at cnt=5: no gap, next period follows seamlessly.
        bus.enable = 1'b1;
        push_period(8, 3, 1, "drain_b");
        push_period(8, 3, 1, "drain_b_next");
        drain(3);
        bus.enable = 1'b0;
        drain(3);
        bus.enable = 1'b1;
        drain_all();

        // Enable falls on the boundary: reload happens and one full period follows.
        bus.enable     = 1'b0;
        bus.duty_cycle = 16'd5;
        push_period(8, 5, 1, "drain_boundary");
        push(1'b0, 1'b0, 1'b0, "drain_boundary_idle");
        drain_all();

        // Zero period: running but silent, and a later nonzero period starts at once.
        bus.period     = 16'd0;
        bus.duty_cycle = 16'd3;
        bus.enable     = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b1, "period0");
        drain_all();
        bus.period     = 16'd4;
        bus.duty_cycle = 16'd1;
        push_period(4, 1, 1, "period0_to4");
        drain_all();
        bus.period = 16'd0;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1, "period0_again");
        drain_all();
        bus.enable = 1'b0;
        push(1'b0, 1'b0, 1'b0, "period0_off");
        push(1'b0, 1'b0, 1'b0, "period0_off");
        drain_all();

        // Asynchronous reset between clock edges.
        bus.period     = 16'd8;
        bus.duty_cycle = 16'd6;
        bus.divisor    = 16'd1;
        bus.enable     = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b1, "pre_reset");
        drain_all();
        #2;
        reset      = 1'b1;
        bus.enable = 1'b0;
        #1;
        check("async_reset", sample(), 3'b000);
        @(negedge clk);
        reset = 1'b0;
        push(1'b0, 1'b0, 1'b0, "post_reset");
        push(1'b0, 1'b0, 1'b0, "post_reset");
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_generator.md
# pwm_generator

Counter/comparator core directly downstream of the PWM control/status register block. Consumes the `enable`, `period`, `duty_cycle` and `divisor` values that the CSR block drives. Produces the `pwm_out` waveform and returns `pwm_running` to the CSR block's status register. Configuration is double-buffered and applied only at period boundaries, so software writes never cause glitches.

## Interface
- `WIDTH`, default 16: width of the period, duty and divisor fields and of the internal counters.
- `clk`  input  1: single clock, rising-edge.
- `reset`  input  1: asynchronous, active-high reset.
- `enable`  input  1: run request from the CSR block (level).
- `period`  input  WIDTH: PWM period, in prescaled ticks.
- `duty_cycle`  input  WIDTH: high time, in prescaled ticks.
- `divisor`  input  WIDTH: clock prescaler. 0 and 1 both mean one tick per clk.
- `pwm_out`  output  1: registered PWM waveform.
- `pwm_running`  output  1: high while a waveform is being produced, including the drain period. Feeds the CSR status register.
- `period_done`  output  1: one-clk pulse in the last clk cycle of every completed period.

## Operation
- Effective divisor: `div_eff = (divisor_sh == 0) ? 1 : divisor_sh`.
- Shadow registers `period_sh`, `duty_sh` and `divisor_sh` load from the inputs at exactly two points:
  - on the IDLE->RUN transition;
  - in the last clk cycle of each period.
  - Input changes at any other time are ignored until the next load.
- Prescaler `pre_cnt` counts 0..div_eff-1 and wraps. `tick = (pre_cnt == div_eff-1)`.
- Period counter `cnt` counts 0..period_sh-1 and advances only on `tick`. It wraps to 0 on the tick where `cnt == period_sh-1`. That cycle is the period's last cycle.
- Output rule: `pwm_out = running && (cnt < duty_sh)`, unsigned compare.
  - `duty_sh >= period_sh` gives a constant high.
  - `duty_sh == 0` gives a constant low.
- `period_sh == 0` (degenerate case):
  - counters hold at 0;
  - `pwm_out` stays 0;
  - `period_done` never fires;
  - shadows reload every clk cycle, so a nonzero period written later takes effect immediately.
- State machine:
  - IDLE: counters at 0, `pwm_out`=0, `pwm_running`=0. Goes to RUN when `enable`=1.
  - RUN: counting.
    - `enable`=0 with `period_sh` nonzero: go to DRAIN.
    - `enable`=0 with `period_sh`=0: go to IDLE on the next edge.
  - DRAIN: keeps counting and outputting the current period.
    - `enable`=1 again: back to RUN with no waveform discontinuity.
    - Last cycle of the period: go to IDLE. No shadow reload.
- `period_done` fires in RUN and DRAIN.
- Simultaneous `enable` falling edge and period boundary while in RUN: enter DRAIN, shadows reload, and one full further period is produced.
- Reset asserted mid-operation: immediately IDLE, all counters and shadows 0, all outputs 0, no drain.

## Timing
- Reset values: `pwm_out`=0, `pwm_running`=0, `period_done`=0, state IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- `enable` sampled high at edge N:
  - from edge N onward, `pwm_running`=1, `cnt`=0, `pre_cnt`=0;
  - `pwm_out` = (`duty_cycle` > 0 && `period` > 0), using the values sampled at edge N.
  - Start-up latency is 1 clk.
- Each period lasts exactly `period_sh*div_eff` clk cycles. `pwm_out` is high for exactly `min(duty_sh, period_sh)*div_eff` of them, at the start of the period.
- `period_done` is high for exactly 1 clk, coinciding with the period's last cycle.
- The new shadow values govern the cycle immediately after the boundary.
- DRAIN exit: `pwm_running` and `pwm_out` fall on the edge ending the last period cycle.
- Counter widths are WIDTH bits. `period` = 2^WIDTH-1 and `divisor` = 2^WIDTH-1 must not overflow.

## Test plan
- Reset with all inputs nonzero:
  - outputs stay 0;
  - `pwm_running` rises 1 clk after `enable`=1.
- `period`=4, `duty_cycle`=1, `divisor`=2, enabled:
  - repeating pattern of 2 clk high then 6 clk low;
  - `period_done` every 8 clk;
  - then `divisor`=0 vs `divisor`=1 both give a 4-clk period.
- Mid-period change from `duty_cycle`=1 to 3, `period`=4:
  - current period unchanged;
  - next period high for 3 ticks.
- `duty_cycle`=5, `period`=4: constant high. `duty_cycle`=0: constant low. Both still give `period_done` every period.
- Drain, `period`=8, `divisor`=1:
  - drop `enable` at `cnt`=2: waveform completes, then `pwm_running` falls right after the `period_done` cycle;
  - repeat, but re-raise `enable` at `cnt`=5: no gap, `pwm_running` stays 1.
- Other boundaries:
  - `period`=0: `pwm_out` stays low and `period_done` absent; dropping `enable` clears `pwm_running` on the next edge;
  - async `reset` pulse mid-period: all outputs 0 immediately, without waiting for a clk edge.
